edge_dilate: RTL and testbench
==============================

// Module: edge_dilate
// PURPOSE
//  - 3x3 binary dilation stage placed directly downstream of the sobel stage, between sobel output and VGA output.
//  - Thickens and bridges broken sobel edges before display.
//  - Consumes the sobel de/hsync/vsync/data stream and emits a stream with identical timing shape, delayed 3 clocks.
//  - Output drives VGA_data as {d,d,d}.
// PARAMETERS
//  H_DISP   640  active pixels per line (line-buffer depth, column limit)
//  V_DISP   480  active lines per frame (row-counter limit)
//  THRESH   128  input pixel counts as "set" when sobel_data >= THRESH (8-bit unsigned)
// PORTS
//  clk           in   1  pixel clock, all logic on rising edge
//  rst           in   1  asynchronous, active-high reset
//  sobel_de      in   1  input data enable, high for H_DISP consecutive clocks per active line
//  sobel_hsync   in   1  input line sync, polarity passed through untouched
//  sobel_vsync   in   1  input frame sync, polarity passed through untouched
//  sobel_data    in   8  input edge pixel (0 / 255 nominal)
//  dilate_de     out  1  sobel_de delayed 3 clocks
//  dilate_hsync  out  1  sobel_hsync delayed 3 clocks
//  dilate_vsync  out  1  sobel_vsync delayed 3 clocks
//  dilate_data   out  8  8'd255 or 8'd0, valid when dilate_de=1, else 8'd0
// BEHAVIOUR
//  - Reset: all outputs, sync/de delay pipes, counters and window registers go to 0 immediately.
//    Line-buffer RAM contents are not cleared; stale bits are masked by the counters.
//  - Binarize: b = (sobel_data >= THRESH). Line buffers store 1 bit per pixel.
//  - Two line buffers, H_DISP x 1 bit each, addressed by col.
//    - While sobel_de=1: read LB0[col], LB1[col]; write LB1[col] <= LB0[col] and LB0[col] <= b.
//  - col counter:
//    - Increments each clock with sobel_de=1; saturates at H_DISP-1 (no further writes).
//    - Cleared on the first clock with sobel_de=0.
//  - row counter:
//    - Increments on each sobel_de falling edge; saturates at V_DISP-1.
//    - Cleared on any sobel_vsync transition; simultaneous vsync edge and de fall => cleared wins.
//  - Window: 3x3 shift registers of {row y, y-1, y-2} x {col x, x-1, x-2}.
//  - Masking:
//    - Rows y-1 / y-2 are forced 0 when row < 1 / < 2.
//    - Columns x-1 / x-2 are forced 0 when col < 1 / < 2.
//    - So no wrap across lines or frames.
//  - Result for input pixel (x,y): dilate_data = 255 if OR of the 9 masked bits is 1, else 0.
//    - Output image is dilation shifted by (+1,+1) pixel; the team accepts this, matching the other window stages.
//  - Latency: exactly 3 clocks from input pixel to dilate_data/dilate_de, all three syncs equally delayed.
//  - Timing: no backpressure, no handshake; one pixel per clock.
//  - Input lines longer than H_DISP: excess pixels output with the window frozen at col H_DISP-1.
//  - Reset asserted mid-frame: output 0 until the next vsync transition. Rows are then counted from 0.
// CONFIGURATION
//  EDGE_ERODE_EN  defined: 3x3 erosion instead of dilation.
//                 - dilate_data = 255 only if AND of the 9 bits is 1.
//                 - Masked (out-of-frame) neighbours count as 1.
//                 - Latency, ports and timing are unchanged.
//                 undefined: dilation as above; erosion logic is not compiled.
// TESTING  (bench: H_DISP=16, V_DISP=8, THRESH=128, continuous frames with blanking)
//  1. rst=1 for 5 clocks mid-line -> all outputs 0 that same cycle; release, next frame output matches model exactly.
//  2. Single 255 at (10,4), rest 0 -> dilate_data=255 at x 10..12, y 4..6 only; 0 elsewhere.
//  3. Single 255 at (15,3) -> 255 only at x=15, y 3..5; x=0,1 of rows 4..6 stay 0 (no line wrap).
//  4. 255 across whole row 7 of frame N, frame N+1 all 0 -> frame N+1 output all 0 (no frame wrap).
//  5. Random 0/255 stream, 3 frames -> dilate_de/hsync/vsync equal inputs delayed exactly 3 clocks; data matches golden model.
//  6. EDGE_ERODE_EN, all-255 frame with single 0 at (5,5) -> 0 at x 5..7, y 5..7; 255 elsewhere including borders.

Source files
------------

// File: rtl/edge_dilate.sv
// 3x3 binary dilation stage between the sobel output and the VGA output.
// Binarizes the sobel pixel stream, keeps two 1-bit line buffers and a 3x3 window,
// and emits the OR of the window as 0/255 with de/hsync/vsync delayed by 3 clocks.
// Define EDGE_ERODE_EN to build a 3x3 erosion (AND of the window, out-of-frame = 1) instead.
module edge_dilate #(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned THRESH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sobel_de,
    input  logic       sobel_hsync,
    input  logic       sobel_vsync,
    input  logic [7:0] sobel_data,
    output logic       dilate_de,
    output logic       dilate_hsync,
    output logic       dilate_vsync,
    output logic [7:0] dilate_data
);

    localparam int unsigned ColW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int unsigned RowW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(H_DISP - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(V_DISP - 1);

    // Value substituted for out-of-frame neighbours: neutral element of the reduction.
`ifdef EDGE_ERODE_EN
    localparam logic Fill = 1'b1;
`else
    localparam logic Fill = 1'b0;
`endif

    // Input-side counters and sync tracking
    logic [ColW-1:0] col_q, col_d;
    logic            sat_q, sat_d;
    logic [RowW-1:0] row_q, row_d;
    logic            frame_ok_q, frame_ok_d;
    logic            de_prev_q;
    logic            vs_prev_q;
    logic            primed_q;

    logic pix_b;
    logic vs_edge;
    logic wr_en;

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2 (contents never reset)
    logic lb0_mem [H_DISP];
    logic lb1_mem [H_DISP];

    // Stage 1: binarized pixel plus line-buffer reads
    logic            s1_de_q, s1_hs_q, s1_vs_q, s1_ok_q, s1_shift_q;
    logic            s1_b_q, s1_lb0_q, s1_lb1_q;
    logic [ColW-1:0] s1_col_q;
    logic [RowW-1:0] s1_row_q;

    // Stage 2: 3x3 window, win_q[c][r], c = 0 is column x, r = 0 is row y
    logic                  s2_de_q, s2_hs_q, s2_vs_q, s2_ok_q;
    logic [ColW-1:0]       s2_col_q;
    logic [2:0][2:0]       win_q;
    logic [2:0]            col_in;
    logic [2:0][2:0]       win_m;
    logic                  hit;
    logic [7:0]            data_d;

    assign pix_b   = (sobel_data >= 8'(THRESH));
    // primed_q suppresses a false vsync edge on the first clock after reset
    assign vs_edge = primed_q && (sobel_vsync != vs_prev_q);
    // Pixels beyond H_DISP neither write the line buffers nor shift the window
    assign wr_en   = sobel_de && !sat_q;

    // Next-state for column/row counters and frame-valid flag
    always_comb begin
        col_d      = col_q;
        sat_d      = sat_q;
        row_d      = row_q;
        frame_ok_d = frame_ok_q | vs_edge;
        if (!sobel_de) begin
            col_d = '0;
            sat_d = 1'b0;
        end else if (col_q == ColLast) begin
            sat_d = 1'b1;
        end else begin
            col_d = col_q + ColW'(1);
        end
        if (vs_edge) begin
            row_d = '0;
        end else if (de_prev_q && !sobel_de && (row_q != RowLast)) begin
            row_d = row_q + RowW'(1);
        end
    end

    // Counter and sync-tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            sat_q      <= 1'b0;
            row_q      <= '0;
            frame_ok_q <= 1'b0;
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            col_q      <= col_d;
            sat_q      <= sat_d;
            row_q      <= row_d;
            frame_ok_q <= frame_ok_d;
            de_prev_q  <= sobel_de;
            vs_prev_q  <= sobel_vsync;
            primed_q   <= 1'b1;
        end
    end

    // Line-buffer writes: shift the column down one row and store the new bit
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            lb1_mem[col_q] <= lb0_mem[col_q];
            lb0_mem[col_q] <= pix_b;
        end
    end

    // Stage 1 register: capture pixel, line-buffer reads and position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_de_q    <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_shift_q <= 1'b0;
            s1_b_q     <= 1'b0;
            s1_lb0_q   <= 1'b0;
            s1_lb1_q   <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
        end else begin
            s1_de_q    <= sobel_de;
            s1_hs_q    <= sobel_hsync;
            s1_vs_q    <= sobel_vsync;
            s1_ok_q    <= frame_ok_q;
            s1_shift_q <= wr_en;
            s1_b_q     <= pix_b;
            s1_lb0_q   <= lb0_mem[col_q];
            s1_lb1_q   <= lb1_mem[col_q];
            s1_col_q   <= col_q;
            s1_row_q   <= row_q;
        end
    end

    // New window column with rows above the frame top replaced by Fill
    always_comb begin
        col_in    = {Fill, Fill, s1_b_q};
        if (s1_row_q >= RowW'(1)) col_in[1] = s1_lb0_q;
        if (s1_row_q >= RowW'(2)) col_in[2] = s1_lb1_q;
    end

    // Stage 2 register: shift the window one column per in-range pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_de_q  <= 1'b0;
            s2_hs_q  <= 1'b0;
            s2_vs_q  <= 1'b0;
            s2_ok_q  <= 1'b0;
            s2_col_q <= '0;
            win_q    <= '0;
        end else begin
            s2_de_q  <= s1_de_q;
            s2_hs_q  <= s1_hs_q;
            s2_vs_q  <= s1_vs_q;
            s2_ok_q  <= s1_ok_q;
            s2_col_q <= s1_col_q;
            if (s1_shift_q) begin
                win_q <= {win_q[1:0], col_in};
            end
        end
    end

    // Mask columns left of the line start, then reduce the window
    always_comb begin
        win_m = win_q;
        if (s2_col_q < ColW'(1)) win_m[1] = {3{Fill}};
        if (s2_col_q < ColW'(2)) win_m[2] = {3{Fill}};
`ifdef EDGE_ERODE_EN
        hit = &win_m;
`else
        hit = |win_m;
`endif
        data_d = (s2_de_q && s2_ok_q && hit) ? 8'd255 : 8'd0;
    end

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dilate_de    <= 1'b0;
            dilate_hsync <= 1'b0;
            dilate_vsync <= 1'b0;
            dilate_data  <= 8'd0;
        end else begin
            dilate_de    <= s2_de_q;
            dilate_hsync <= s2_hs_q;
            dilate_vsync <= s2_vs_q;
            dilate_data  <= data_d;
        end
    end

endmodule

// File: tb/tb_edge_dilate.sv
// Randomized bench for edge_dilate (H_DISP=16, V_DISP=8, THRESH=128) against a frame-level
// reference model. Honours EDGE_ERODE_EN the same way the design does.
module tb_edge_dilate;

    localparam int unsigned H  = 16;
    localparam int unsigned V  = 8;
    localparam int unsigned TH = 128;
`ifdef EDGE_ERODE_EN
    localparam bit Erode = 1'b1;
`else
    localparam bit Erode = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       de = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic [7:0] data = 8'd0;
    logic       o_de, o_hs, o_vs;
    logic [7:0] o_data;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int ones   = 0;

    int unsigned pix [V][H];
    bit          mimg [V][H];

    bit         e_de [64];
    bit         e_hs [64];
    bit         e_vs [64];
    logic [7:0] e_d  [64];

    edge_dilate #(
        .H_DISP(H),
        .V_DISP(V),
        .THRESH(TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sobel_de    (de),
        .sobel_hsync (hs),
        .sobel_vsync (vs),
        .sobel_data  (data),
        .dilate_de   (o_de),
        .dilate_hsync(o_hs),
        .dilate_vsync(o_vs),
        .dilate_data (o_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reduction over the 3x3 neighbourhood ending at (x,y); out-of-frame cells are neutral.
    function automatic bit win_hit(input int x, input int y);
        bit acc;
        bit nb;
        acc = Erode;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                if ((y - dy) < 0 || (x - dx) < 0) nb = Erode;
                else nb = mimg[y - dy][x - dx];
                if (Erode) acc = acc & nb;
                else acc = acc | nb;
            end
        end
        return acc;
    endfunction

    // Reference model: tracks pixel position from the syncs and predicts each output
    initial begin
        int  mx, my, idx, xc;
        bit  pde, pvs, primed, valid;
        mx = 0; my = 0; pde = 0; pvs = 0; primed = 0; valid = 0;
        forever begin
            @(posedge clk);
            idx = edges % 64;
            if (rst) begin
                e_de[idx] = 0; e_hs[idx] = 0; e_vs[idx] = 0; e_d[idx] = 8'd0;
                mx = 0; my = 0; pde = 0; pvs = 0; primed = 0; valid = 0;
            end else begin
                e_de[idx] = de; e_hs[idx] = hs; e_vs[idx] = vs; e_d[idx] = 8'd0;
                if (de) begin
                    xc = (mx < int'(H)) ? mx : int'(H) - 1;
                    if (mx < int'(H)) mimg[my][xc] = (data >= 8'(TH));
                    if (valid && win_hit(xc, my)) e_d[idx] = 8'd255;
                end
                if (primed && (vs != pvs)) begin
                    valid = 1;
                    my = 0;
                end else if (pde && !de && my < int'(V) - 1) begin
                    my++;
                end
                mx = de ? mx + 1 : 0;
                pde = de; pvs = vs; primed = 1;
            end
            edges++;
        end
    end

    // Output monitor: outputs equal the prediction for the input two edges earlier
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (edges > 0) begin
                    check("rst_de", o_de, 0);
                    check("rst_data", o_data, 0);
                end
            end else if (edges >= 3) begin
                idx = (edges - 3) % 64;
                check("de", o_de, e_de[idx]);
                check("hsync", o_hs, e_hs[idx]);
                check("vsync", o_vs, e_vs[idx]);
                check("data", o_data, e_d[idx]);
                if (o_de && o_data == 8'd255) ones++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned rand_pix();
        case ($urandom_range(0, 5))
            0, 1:    return 0;
            2, 3:    return 255;
            4:       return $urandom_range(127, 128);
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    task automatic fill_rand();
        for (int y = 0; y < int'(V); y++)
            for (int x = 0; x < int'(H); x++) pix[y][x] = rand_pix();
    endtask

    task automatic fill_const(input int unsigned v);
        for (int y = 0; y < int'(V); y++)
            for (int x = 0; x < int'(H); x++) pix[y][x] = v;
    endtask

    // One frame: vsync pulse, then V lines of hblank + H active pixels, then trailing blank.
    // rst_line >= 0 pulses reset for 5 clocks in the middle of that line.
    task automatic drive_frame(input int rst_line);
        for (int i = 0; i < 3; i++) begin
            tick(); de = 0; hs = 0; vs = 1; data = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); vs = 0;
        end
        for (int y = 0; y < int'(V); y++) begin
            for (int i = 0; i < 6; i++) begin
                tick(); de = 0; hs = (i < 2); data = 8'($urandom);
            end
            for (int x = 0; x < int'(H); x++) begin
                tick(); de = 1; hs = 0; data = 8'(pix[y][x]);
                if (y == rst_line && x == 5) begin
                    rst = 1;
                    #1;
                    check("rst_now_de", o_de, 0);
                    check("rst_now_hs", o_hs, 0);
                    check("rst_now_vs", o_vs, 0);
                    check("rst_now_data", o_data, 0);
                end
                if (y == rst_line && x == 10) rst = 0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(); de = 0; hs = 0; data = 8'd0;
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", o_data, 0);
        check("reset_de", o_de, 0);
        rst = 0;

        fill_rand(); drive_frame(-1);
        // Mid-line reset, then a clean frame that must match exactly
        fill_rand(); drive_frame(3);
        fill_rand(); drive_frame(-1);

        fill_const(0); pix[4][10] = 255; ones = 0; drive_frame(-1);
        check("single_pixel_ones", ones, Erode ? 0 : 9);

        fill_const(0); pix[3][15] = 255; ones = 0; drive_frame(-1);
        check("right_edge_ones", ones, Erode ? 0 : 3);

        fill_const(0);
        for (int x = 0; x < int'(H); x++) pix[7][x] = 255;
        ones = 0; drive_frame(-1);
        check("last_row_ones", ones, Erode ? 0 : 16);
        fill_const(0); ones = 0; drive_frame(-1);
        check("no_frame_wrap_ones", ones, 0);

        for (int f = 0; f < 3; f++) begin
            fill_rand(); drive_frame(-1);
        end

        fill_const(255); pix[5][5] = 0; ones = 0; drive_frame(-1);
        check("hole_ones", ones, Erode ? 119 : 128);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
